usart_tx: RTL and testbench

USART_TX -- requirements
Module: usart_tx

---
 rtl/avr_io_pkg.sv | 37 +++
 rtl/usart_baud_timer.sv | 41 ++++
 rtl/usart_tx.sv | 179 +++++++++++++++++
 tb/tb_usart_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_io_pkg.sv
// Shared AVR IO definitions for the USART transmitter: register bit positions,
// IO addresses, reset values and the transmit state encoding.
package avr_io_pkg;

  localparam int unsigned UcsraTxc   = 6;
  localparam int unsigned UcsraUdre  = 5;
  localparam int unsigned UcsraU2x   = 1;
  localparam int unsigned UcsrbTxcie = 6;
  localparam int unsigned UcsrbUdrie = 5;
  localparam int unsigned UcsrbTxen  = 3;

  localparam logic [5:0] IoAddrUbrrl = 6'h09;
  localparam logic [5:0] IoAddrUcsrb = 6'h0A;
  localparam logic [5:0] IoAddrUcsra = 6'h0B;
  localparam logic [5:0] IoAddrUdr   = 6'h0C;

  localparam logic [7:0]  UcsraRst = 8'h20;
  localparam logic [7:0]  UcsrbRst = 8'h00;
  localparam logic [11:0] UbrrRst  = 12'h000;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Last counter value of a bit period: 16*(UBRR+1)-1, or 8*(UBRR+1)-1 with U2X.
  function automatic logic [15:0] bit_limit(input logic [11:0] ubrr, input logic u2x);
    logic [12:0] n;
    logic [16:0] p;
    n = {1'b0, ubrr} + 13'd1;
    p = u2x ? {1'b0, n, 3'b000} : {n, 4'b0000};
    return 16'(p - 17'd1);
  endfunction

endpackage

// File: rtl/usart_baud_timer.sv
// Bit-period timer: counts one bit period and pulses bit_end_o on its last cycle.
// The period is sampled from UBRR/U2X only when the timer reloads.
module usart_baud_timer
  import avr_io_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] ubrr_i,
  input  logic        u2x_i,
  input  logic        restart_i,
  output logic        bit_end_o,
  output logic        bit_last_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] limit_q, limit_d;

  assign bit_end_o  = (cnt_q == limit_q);
  // One cycle before bit_end_o; the period is never shorter than 8 cycles.
  assign bit_last_o = (cnt_q == (limit_q - 16'd1));

  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    limit_d = limit_q;
    if (restart_i || bit_end_o) begin
      cnt_d   = '0;
      limit_d = bit_limit(ubrr_i, u2x_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      limit_q <= bit_limit(UbrrRst, 1'b0);
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/usart_tx.sv
// AVR-style USART transmitter: double-buffered 8N1 serialiser with UCSRA/UCSRB/UBRR
// registers and UDRE/TXC interrupt requests.
module usart_tx
  import avr_io_pkg::*;
(
  input  logic       sysClock,
  input  logic       rst,
  input  logic       UDR_write_enable,
  input  logic [7:0] UDR_input_data,
  input  logic       UCSRA_write_enable,
  input  logic [7:0] UCSRA_input_data,
  input  logic       UCSRB_write_enable,
  input  logic [7:0] UCSRB_input_data,
  input  logic       UBRRL_write_enable,
  input  logic [7:0] UBRRL_input_data,
  input  logic       UBRRH_write_enable,
  input  logic [7:0] UBRRH_input_data,
  output logic       TXD,
  output logic [7:0] UCSRA_output,
  output logic [7:0] UCSRB_output,
  output logic [7:0] UBRRL_output,
  output logic [7:0] UBRRH_output,
  output logic       udre_irq,
  output logic       txc_irq
);

  tx_state_e   state_q, state_d;
  logic [7:0]  buf_q, buf_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        txd_q, txd_d;
  logic        udre_q, udre_d;
  logic        txc_q, txc_d;
  logic        u2x_q, u2x_d;
  logic        txcie_q, txcie_d;
  logic        udrie_q, udrie_d;
  logic        txen_q, txen_d;
  logic [7:0]  ubrrl_q, ubrrl_d;
  logic [3:0]  ubrrh_q, ubrrh_d;
  logic        load;
  logic        bit_end, bit_last;

  usart_baud_timer u_baud_timer (
    .clk_i      (sysClock),
    .rst_i      (rst),
    .ubrr_i     ({ubrrh_q, ubrrl_q}),
    .u2x_i      (u2x_q),
    .restart_i  (load),
    .bit_end_o  (bit_end),
    .bit_last_o (bit_last)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    udre_d    = udre_q;
    txc_d     = txc_q;
    u2x_d     = u2x_q;
    txcie_d   = txcie_q;
    udrie_d   = udrie_q;
    txen_d    = txen_q;
    ubrrl_d   = ubrrl_q;
    ubrrh_d   = ubrrh_q;
    load      = 1'b0;

    if (UCSRA_write_enable) u2x_d = UCSRA_input_data[UcsraU2x];
    if (UCSRB_write_enable) begin
      txcie_d = UCSRB_input_data[UcsrbTxcie];
      udrie_d = UCSRB_input_data[UcsrbUdrie];
      txen_d  = UCSRB_input_data[UcsrbTxen];
    end
    if (UBRRL_write_enable) ubrrl_d = UBRRL_input_data;
    if (UBRRH_write_enable) ubrrh_d = UBRRH_input_data[3:0];

    // A full buffer (udre_q=0) cannot also accept a write, so load and write never collide.
    if (UDR_write_enable && udre_q) begin
      buf_d  = UDR_input_data;
      udre_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!udre_q && txen_q) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        // A buffered byte always follows on, even with TXEN cleared.
        if (bit_end) begin
          if (!udre_q) load = 1'b1;
          else         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d = buf_q;
      udre_d  = 1'b1;
      txd_d   = 1'b0;
      state_d = StStart;
    end

    if (UCSRA_write_enable && UCSRA_input_data[UcsraTxc]) txc_d = 1'b0;
    // Set wins over a same-cycle clear.
    if (state_q == StStop && bit_last && udre_q) txc_d = 1'b1;
  end

  always_ff @(posedge sysClock) begin
    if (rst) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      udre_q    <= UcsraRst[UcsraUdre];
      txc_q     <= UcsraRst[UcsraTxc];
      u2x_q     <= UcsraRst[UcsraU2x];
      txcie_q   <= UcsrbRst[UcsrbTxcie];
      udrie_q   <= UcsrbRst[UcsrbUdrie];
      txen_q    <= UcsrbRst[UcsrbTxen];
      ubrrl_q   <= UbrrRst[7:0];
      ubrrh_q   <= UbrrRst[11:8];
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      udre_q    <= udre_d;
      txc_q     <= txc_d;
      u2x_q     <= u2x_d;
      txcie_q   <= txcie_d;
      udrie_q   <= udrie_d;
      txen_q    <= txen_d;
      ubrrl_q   <= ubrrl_d;
      ubrrh_q   <= ubrrh_d;
    end
  end

  always_comb begin
    UCSRA_output            = '0;
    UCSRA_output[UcsraTxc]  = txc_q;
    UCSRA_output[UcsraUdre] = udre_q;
    UCSRA_output[UcsraU2x]  = u2x_q;
    UCSRB_output             = '0;
    UCSRB_output[UcsrbTxcie] = txcie_q;
    UCSRB_output[UcsrbUdrie] = udrie_q;
    UCSRB_output[UcsrbTxen]  = txen_q;
  end

  assign UBRRL_output = ubrrl_q;
  assign UBRRH_output = {4'b0000, ubrrh_q};
  assign TXD          = txd_q;
  assign udre_irq     = udre_q & udrie_q;
  assign txc_irq      = txc_q & txcie_q;

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx: register read-back vectors, table-driven frames
// decoded from TXD against a scoreboard, and hand-written multi-cycle corner cases.
module tb_usart_tx;

  logic       sysClock = 1'b0;
  logic       rst;
  logic       UDR_write_enable, UCSRA_write_enable, UCSRB_write_enable;
  logic       UBRRL_write_enable, UBRRH_write_enable;
  logic [7:0] UDR_input_data, UCSRA_input_data, UCSRB_input_data;
  logic [7:0] UBRRL_input_data, UBRRH_input_data;
  logic       TXD, udre_irq, txc_irq;
  logic [7:0] UCSRA_output, UCSRB_output, UBRRL_output, UBRRH_output;

  usart_tx dut (
    .sysClock           (sysClock),
    .rst                (rst),
    .UDR_write_enable   (UDR_write_enable),
    .UDR_input_data     (UDR_input_data),
    .UCSRA_write_enable (UCSRA_write_enable),
    .UCSRA_input_data   (UCSRA_input_data),
    .UCSRB_write_enable (UCSRB_write_enable),
    .UCSRB_input_data   (UCSRB_input_data),
    .UBRRL_write_enable (UBRRL_write_enable),
    .UBRRL_input_data   (UBRRL_input_data),
    .UBRRH_write_enable (UBRRH_write_enable),
    .UBRRH_input_data   (UBRRH_input_data),
    .TXD                (TXD),
    .UCSRA_output       (UCSRA_output),
    .UCSRB_output       (UCSRB_output),
    .UBRRL_output       (UBRRL_output),
    .UBRRH_output       (UBRRH_output),
    .udre_irq           (udre_irq),
    .txc_irq            (txc_irq)
  );

  always #5 sysClock = ~sysClock;

  int cyc = 0;
  always @(posedge sysClock) cyc <= cyc + 1;

  localparam int SelUcsra = 0, SelUcsrb = 1, SelUbrrl = 2, SelUbrrh = 3;

  typedef struct {
    int         sel;
    logic [7:0] wdata;
    logic [7:0] rexp;
    logic       udre_irq_exp;
  } reg_vec_t;

  typedef struct {
    logic [7:0] ubrrl;
    logic       u2x;
    logic [7:0] data;
    int         bit_len;
  } frame_vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] d1, d2;
  int         s1, s2, t1, t2, n, m;
  bit         ok1, ok2;

  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one register write in the current cycle; returns in the following cycle.
  task automatic wr_reg(input int sel, input logic [7:0] d);
    case (sel)
      SelUcsra: begin UCSRA_write_enable = 1'b1; UCSRA_input_data = d; end
      SelUcsrb: begin UCSRB_write_enable = 1'b1; UCSRB_input_data = d; end
      SelUbrrl: begin UBRRL_write_enable = 1'b1; UBRRL_input_data = d; end
      default:  begin UBRRH_write_enable = 1'b1; UBRRH_input_data = d; end
    endcase
    tick();
    UCSRA_write_enable = 1'b0;
    UCSRB_write_enable = 1'b0;
    UBRRL_write_enable = 1'b0;
    UBRRH_write_enable = 1'b0;
  endtask

  task automatic wr_udr(input logic [7:0] d);
    UDR_write_enable = 1'b1;
    UDR_input_data   = d;
    tick();
    UDR_write_enable = 1'b0;
  endtask

  function automatic logic [7:0] rd(input int sel);
    case (sel)
      SelUcsra: return UCSRA_output;
      SelUcsrb: return UCSRB_output;
      SelUbrrl: return UBRRL_output;
      default:  return UBRRH_output;
    endcase
  endfunction

  // Wait (bounded) for a start bit, then sample every cycle of a 10-bit frame; each bit
  // must hold for exactly bit_len cycles. Also records the first cycle TXC reads 1.
  task automatic recv_frame(input int bl, input int budget, output logic [7:0] data,
                            output int start_cyc, output int txc_cyc, output bit ok);
    int         waited = 0;
    logic [9:0] bits = '1;
    bit         stable = 1'b1;
    ok = 1'b0; data = '0; start_cyc = -1; txc_cyc = -1;
    while (TXD !== 1'b0 && waited < budget) begin
      tick();
      waited++;
    end
    if (TXD !== 1'b0) return;
    start_cyc = cyc;
    for (int k = 0; k < 10 * bl; k++) begin
      if (k % bl == 0) bits[k / bl] = TXD;
      else if (TXD !== bits[k / bl]) stable = 1'b0;
      if (txc_cyc < 0 && UCSRA_output[6] === 1'b1) txc_cyc = cyc;
      tick();
    end
    data = bits[8:1];
    ok = stable && bits[0] == 1'b0 && bits[9] == 1'b1;
  endtask

  task automatic score(input string name, input logic [7:0] data, input bit ok);
    check({name, "_frame_ok"}, 32'(ok), 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got byte 0x%0h, expected no frame", name, data);
    end else begin
      check({name, "_data"}, 32'(data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic expect_idle(input string name, input int ncyc);
    int bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (TXD !== 1'b1) bad++;
      tick();
    end
    check(name, 32'(bad), 32'd0);
  endtask

  reg_vec_t   rv[8];
  frame_vec_t fv[6];

  initial begin
    rv[0] = '{SelUbrrh, 8'hFF, 8'h0F, 1'b0};
    rv[1] = '{SelUbrrl, 8'h5A, 8'h5A, 1'b0};
    rv[2] = '{SelUcsrb, 8'hFF, 8'h68, 1'b1};
    rv[3] = '{SelUcsra, 8'hFF, 8'h22, 1'b1};
    rv[4] = '{SelUcsra, 8'h00, 8'h20, 1'b1};
    rv[5] = '{SelUcsrb, 8'h00, 8'h00, 1'b0};
    rv[6] = '{SelUbrrh, 8'h00, 8'h00, 1'b0};
    rv[7] = '{SelUbrrl, 8'h00, 8'h00, 1'b0};

    fv[0] = '{8'd0, 1'b0, 8'hA5, 16};
    fv[1] = '{8'd0, 1'b1, 8'h3C, 8};
    fv[2] = '{8'd1, 1'b0, 8'h81, 32};
    fv[3] = '{8'd3, 1'b1, 8'h6E, 32};
    fv[4] = '{8'd2, 1'b1, 8'h00, 24};
    fv[5] = '{8'd0, 1'b0, 8'hFF, 16};

    rst = 1'b1;
    UDR_write_enable = 0; UCSRA_write_enable = 0; UCSRB_write_enable = 0;
    UBRRL_write_enable = 0; UBRRH_write_enable = 0;
    UDR_input_data = 0; UCSRA_input_data = 0; UCSRB_input_data = 0;
    UBRRL_input_data = 0; UBRRH_input_data = 0;
    tick();
    tick();
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_ucsra", 32'(UCSRA_output), 32'h20);
    check("rst_ucsrb", 32'(UCSRB_output), 32'h00);
    check("rst_ubrr", 32'({UBRRH_output, UBRRL_output}), 32'h0000);
    check("rst_irqs", 32'({udre_irq, txc_irq}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr_reg(rv[i].sel, rv[i].wdata);
      check($sformatf("reg_rb%0d", i), 32'(rd(rv[i].sel)), 32'(rv[i].rexp));
      check($sformatf("reg_udre_irq%0d", i), 32'(udre_irq), 32'(rv[i].udre_irq_exp));
    end

    for (int i = 0; i < 6; i++) begin
      wr_reg(SelUbrrl, fv[i].ubrrl);
      wr_reg(SelUcsra, {6'b010000, fv[i].u2x, 1'b0});
      wr_reg(SelUcsrb, 8'h08);
      n = cyc;
      wr_udr(fv[i].data);
      exp_q.push_back(fv[i].data);
      check($sformatf("frm%0d_udre_n1", i), 32'(UCSRA_output[5]), 32'd0);
      tick();
      check($sformatf("frm%0d_udre_n2", i), 32'(UCSRA_output[5]), 32'd1);
      recv_frame(fv[i].bit_len, 10, d1, s1, t1, ok1);
      score($sformatf("frm%0d", i), d1, ok1);
      check($sformatf("frm%0d_start", i), 32'(s1), 32'(n + 2));
      check($sformatf("frm%0d_txc", i), 32'(t1), 32'(n + 1 + 10 * fv[i].bit_len));
    end

    // Interrupt outputs: TXC is still set from the last frame.
    wr_reg(SelUcsrb, 8'h48);
    check("txc_irq_set", 32'(txc_irq), 32'd1);
    wr_reg(SelUcsra, 8'h40);
    check("txc_clr", 32'(UCSRA_output[6]), 32'd0);
    check("txc_irq_clr", 32'(txc_irq), 32'd0);
    wr_reg(SelUcsrb, 8'h28);
    check("udre_irq_set", 32'(udre_irq), 32'd1);
    wr_udr(8'h99);
    exp_q.push_back(8'h99);
    check("udre_irq_full", 32'(udre_irq), 32'd0);
    tick();
    check("udre_irq_reload", 32'(udre_irq), 32'd1);
    recv_frame(16, 10, d1, s1, t1, ok1);
    score("irq_frm", d1, ok1);

    // Back-to-back frames, plus a dropped third write while the buffer is full.
    wr_reg(SelUcsra, 8'h40);
    wr_reg(SelUcsrb, 8'h08);
    wr_udr(8'h55);
    exp_q.push_back(8'h55);
    fork
      begin
        recv_frame(16, 10, d1, s1, t1, ok1);
        recv_frame(16, 10, d2, s2, t2, ok2);
      end
      begin
        repeat (20) tick();
        check("b2b_udre_before", 32'(UCSRA_output[5]), 32'd1);
        wr_udr(8'h0F);
        exp_q.push_back(8'h0F);
        repeat (5) tick();
        check("b2b_udre_full", 32'(UCSRA_output[5]), 32'd0);
        wr_udr(8'hAA);
      end
    join
    score("b2b_first", d1, ok1);
    score("b2b_second", d2, ok2);
    check("b2b_no_gap", 32'(s2), 32'(s1 + 160));
    check("b2b_no_txc_first", 32'(t1), 32'hFFFF_FFFF);
    check("b2b_txc_second", 32'(t2), 32'(s2 + 159));
    expect_idle("b2b_no_third", 60);

    // TXEN cleared: the write is buffered but nothing is sent until TXEN is set.
    wr_reg(SelUcsrb, 8'h00);
    wr_reg(SelUcsra, 8'h40);
    wr_udr(8'h3C);
    exp_q.push_back(8'h3C);
    expect_idle("txen_off_idle", 30);
    check("txen_off_udre", 32'(UCSRA_output[5]), 32'd0);
    m = cyc;
    wr_reg(SelUcsrb, 8'h08);
    recv_frame(16, 10, d1, s1, t1, ok1);
    score("txen_on", d1, ok1);
    check("txen_on_start", 32'(s1), 32'(m + 2));

    // Reset in the middle of data bit 0 with a second byte buffered.
    n = cyc;
    wr_udr(8'h00);
    tick();
    wr_udr(8'h77);
    repeat (18) tick();
    check("rst_mid_txd_before", 32'(TXD), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_txd", 32'(TXD), 32'd1);
    check("rst_mid_ucsra", 32'(UCSRA_output), 32'h20);
    check("rst_mid_ucsrb", 32'(UCSRB_output), 32'h00);
    exp_q.delete();
    wr_reg(SelUcsrb, 8'h08);
    expect_idle("rst_mid_no_frame", 200);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
